arith_unit_seq: RTL and testbench

//  Parametrised, sequential successor to the 4-bit combinational arithmetic unit.

---
 rtl/arith_unit_seq.sv | 178 +++++++++++++++++
 tb/tb_arith_unit_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_seq.sv
// Sequential signed arithmetic unit: add, sub, negate in one cycle, iterative
// shift-add multiply in WIDTH cycles, with wrap or saturate on overflow.
module arith_unit_seq #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             overflow,
  output logic             busy,
  output logic             ov_sticky,
  input  logic             ov_clr,
  output logic [1:0]       dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]    HALF    = PW'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. The producer holds its payload stable while valid=1 and ready=0;
  // valid never depends combinationally on ready.

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              ov_q, ov_d;
  logic              ov_sticky_q, ov_sticky_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic [CW-1:0]     count_q, count_d;

  logic [WIDTH:0]    ext_a, ext_b, as_res;
  logic              as_ov;
  logic [WIDTH-1:0]  as_val;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [PW-1:0]     acc_step;
  logic [WIDTH-1:0]  prod_lo;
  logic              mul_ov;
  logic [WIDTH-1:0]  mul_val;

  // Add/sub/neg evaluated one bit wider so the exact result is always held.
  always_comb begin
    ext_a  = {A[WIDTH-1], A};
    ext_b  = {B[WIDTH-1], B};
    as_res = '0;
    case (sel)
      2'b00:   as_res = ext_a + ext_b;
      2'b01:   as_res = ext_a - ext_b;
      default: as_res = '0 - ext_a;
    endcase
    as_ov  = as_res[WIDTH] ^ as_res[WIDTH-1];
    as_val = as_res[WIDTH-1:0];
    if (SATURATE && as_ov) begin
      as_val = as_res[WIDTH] ? MIN_NEG : MAX_POS;
    end
  end

  // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
  always_comb begin
    mag_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    mag_b = B[WIDTH-1] ? (~B + 1'b1) : B;
  end

  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod_lo  = sign_q ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
    // A negative product may reach magnitude 2^(WIDTH-1); a positive one may not.
    mul_ov   = sign_q ? (acc_step > HALF) : (acc_step >= HALF);
    mul_val  = prod_lo;
    if (SATURATE && mul_ov) begin
      mul_val = sign_q ? MIN_NEG : MAX_POS;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    ov_d     = ov_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (sel == 2'b10) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = PW'(mag_a);
            mplier_d = mag_b;
            sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
            count_d  = '0;
          end else begin
            state_d = DONE;
            q_d     = as_val;
            ov_d    = as_ov;
          end
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          q_d     = mul_val;
          ov_d    = mul_ov;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A delivered overflow sets the sticky bit even when a clear arrives on the same edge.
  always_comb begin
    ov_sticky_d = (ov_sticky_q & ~ov_clr) | ((state_q == DONE) & out_ready & ov_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      ov_q        <= 1'b0;
      ov_sticky_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      ov_q        <= ov_d;
      ov_sticky_q <= ov_sticky_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    Q         = q_q;
    overflow  = ov_q;
    ov_sticky = ov_sticky_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq: wrap and saturate instances driven in lockstep,
// directed vector table, corner sequences, exhaustive sweep and random ops.
module tb_arith_unit_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A, B;
  logic [1:0]   sel;
  logic         out_ready;
  logic         ov_clr;

  logic         in_ready_w, out_valid_w, overflow_w, busy_w, ov_sticky_w;
  logic [W-1:0] q_w;
  logic [1:0]   dbg_w;
  logic         in_ready_s, out_valid_s, overflow_s, busy_s, ov_sticky_s;
  logic [W-1:0] q_s;
  logic [1:0]   dbg_s;

  int checks = 0;
  int errors = 0;
  bit sticky_m = 1'b0;
  logic [2*W+1:0] exp_q[$];

  arith_unit_seq #(.WIDTH(W), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid_w), .out_ready(out_ready),
    .Q(q_w), .overflow(overflow_w), .busy(busy_w), .ov_sticky(ov_sticky_w),
    .ov_clr(ov_clr), .dbg_state(dbg_w)
  );

  arith_unit_seq #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid_s), .out_ready(out_ready),
    .Q(q_s), .overflow(overflow_s), .busy(busy_s), .ov_sticky(ov_sticky_s),
    .ov_clr(ov_clr), .dbg_state(dbg_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic [W-1:0] qw;
    logic [W-1:0] qs;
    logic         ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exact integer result, then range test and wrap/clamp.
  function automatic logic [W:0] ref_model(input logic [1:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input bit sat);
    int ia, ib, r, max_i, min_i;
    logic ov;
    logic [W-1:0] q;
    ia    = int'($signed(a));
    ib    = int'($signed(b));
    max_i = (1 << (W - 1)) - 1;
    min_i = -(1 << (W - 1));
    case (s)
      2'd0:    r = ia + ib;
      2'd1:    r = ia - ib;
      2'd2:    r = ia * ib;
      default: r = -ia;
    endcase
    ov = (r > max_i) || (r < min_i);
    if (ov && sat) q = (r > 0) ? W'(max_i) : W'(min_i);
    else           q = r[W-1:0];
    return {ov, q};
  endfunction

  // Entered and left at a falling edge with both units idle.
  task automatic run_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic [W-1:0] eqw, input logic [W-1:0] eqs,
                        input logic eov, input bit clr_at_release, input string tag);
    int lat;
    logic [2*W+1:0] e;
    chk({tag, " in_ready"}, in_ready_w, 1'b1);
    in_valid = 1'b1; sel = s; A = a; B = b;
    exp_q.push_back({eov, eqs, eov, eqw});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0; A = W'($urandom); B = W'($urandom); sel = 2'($urandom);
      end
    end while (!out_valid_w && lat < 40);
    chk({tag, " latency"}, lat, (s == 2'd2) ? W + 1 : 1);
    e = exp_q.pop_front();
    chk({tag, " q_wrap"}, q_w, e[W-1:0]);
    chk({tag, " ov_wrap"}, overflow_w, e[W]);
    chk({tag, " q_sat"}, q_s, e[2*W:W+1]);
    chk({tag, " ov_sat"}, overflow_s, e[2*W+1]);
    chk({tag, " out_valid_sat"}, out_valid_s, 1'b1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; A = W'($urandom); B = W'($urandom); sel = 2'($urandom);
      @(negedge clk);
      chk({tag, " held out_valid"}, out_valid_w, 1'b1);
      chk({tag, " held in_ready"}, in_ready_w, 1'b0);
      chk({tag, " held q"}, q_w, eqw);
      chk({tag, " held q_sat"}, q_s, eqs);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ov_clr    = clr_at_release;
    @(negedge clk);
    out_ready = 1'b0;
    ov_clr    = 1'b0;
    sticky_m  = (clr_at_release ? 1'b0 : sticky_m) | eov;
    chk({tag, " released out_valid"}, out_valid_w, 1'b0);
    chk({tag, " released busy"}, busy_w, 1'b0);
    chk({tag, " ov_sticky"}, ov_sticky_w, sticky_m);
    chk({tag, " ov_sticky_sat"}, ov_sticky_s, sticky_m);
  endtask

  task automatic run_ref(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string tag);
    logic [W:0] rw, rs;
    rw = ref_model(s, a, b, 1'b0);
    rs = ref_model(s, a, b, 1'b1);
    run_op(s, a, b, hold, rw[W-1:0], rs[W-1:0], rw[W], 1'b0, tag);
  endtask

  vec_t vecs[$];
  int   cnt;

  initial begin
    vecs = '{
      '{2'd0, 4'h7, 4'h1, 0, 4'h8, 4'h7, 1'b1},
      '{2'd1, 4'h8, 4'h1, 0, 4'h7, 4'h8, 1'b1},
      '{2'd3, 4'h8, 4'h5, 0, 4'h8, 4'h7, 1'b1},
      '{2'd3, 4'h3, 4'h0, 0, 4'hD, 4'hD, 1'b0},
      '{2'd2, 4'h3, 4'hE, 0, 4'hA, 4'hA, 1'b0},
      '{2'd2, 4'h8, 4'hF, 0, 4'h8, 4'h7, 1'b1},
      '{2'd2, 4'h4, 4'h4, 3, 4'h0, 4'h7, 1'b1},
      '{2'd0, 4'h3, 4'h2, 3, 4'h5, 4'h5, 1'b0},
      '{2'd1, 4'h2, 4'h5, 1, 4'hD, 4'hD, 1'b0},
      '{2'd2, 4'h8, 4'h1, 0, 4'h8, 4'h8, 1'b0},
      '{2'd2, 4'h7, 4'h7, 0, 4'h1, 4'h7, 1'b1},
      '{2'd2, 4'hD, 4'h3, 2, 4'h7, 4'h8, 1'b1},
      '{2'd2, 4'h0, 4'h8, 0, 4'h0, 4'h0, 1'b0},
      '{2'd0, 4'h8, 4'h8, 0, 4'h0, 4'h8, 1'b1}
    };

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0; out_ready = 1'b0; ov_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset q", q_w, 0);
    chk("reset overflow", overflow_w, 0);
    chk("reset out_valid", out_valid_w, 0);
    chk("reset busy", busy_w, 0);
    chk("reset ov_sticky", ov_sticky_w, 0);
    chk("reset in_ready", in_ready_w, 0);
    chk("reset in_ready_sat", in_ready_s, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].qw, vecs[i].qs,
             vecs[i].ov, 1'b0, $sformatf("vec%0d", i));

    // Reset while the multiplier is iterating.
    in_valid = 1'b1; sel = 2'd2; A = 4'h3; B = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-mul reset busy", busy_w, 0);
    chk("mid-mul reset out_valid", out_valid_w, 0);
    chk("mid-mul reset q", q_w, 0);
    chk("mid-mul reset overflow", overflow_w, 0);
    chk("mid-mul reset ov_sticky", ov_sticky_w, 0);
    chk("mid-mul reset in_ready", in_ready_w, 0);
    rst = 1'b0;
    sticky_m = 1'b0;
    cnt = 0;
    repeat (7) begin
      @(negedge clk);
      if (out_valid_w) cnt++;
    end
    chk("aborted op delivered", cnt, 0);
    run_op(2'd2, 4'h3, 4'hE, 0, 4'hA, 4'hA, 1'b0, 1'b0, "after reset mul");

    // Clear and set on the same handshake edge: set wins; later clear alone empties it.
    run_op(2'd0, 4'h7, 4'h1, 0, 4'h8, 4'h7, 1'b1, 1'b1, "clr+set same edge");
    run_op(2'd0, 4'h1, 4'h1, 0, 4'h2, 4'h2, 1'b0, 1'b1, "clr on clean handshake");
    run_op(2'd3, 4'h8, 4'h0, 0, 4'h8, 4'h7, 1'b1, 1'b0, "re-set sticky");
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    sticky_m = 1'b0;
    chk("ov_clr alone", ov_sticky_w, 0);

    // Throughput with out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1; sel = 2'd0; A = 4'h1; B = 4'h1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_w) cnt++;
    end
    chk("add throughput", cnt, 10);
    sel = 2'd2;
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid_w) cnt++;
    end
    in_valid = 1'b0;
    chk("mul throughput", cnt, 4);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("throughput idle", busy_w, 0);

    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_ref(2'(s), 4'(a), 4'(b), $urandom_range(0, 2), $sformatf("sweep s%0d a%0h b%0h", s, a, b));

    for (int i = 0; i < 200; i++)
      run_ref(2'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3), $sformatf("rand%0d", i));

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
